itcm_boot_loader: RTL and testbench
===================================

ITCM_BOOT_LOADER -- requirements
Module: itcm_boot_loader

Interface
REQ-001 SHALL have parameter FLASH_BASE, default 24'h000000, flash byte address of first image byte.
REQ-002 SHALL have parameter WORD_COUNT, default 1024, number of 32-bit words copied (1..65536).
REQ-003 SHALL have parameter CLK_DIV, default 2, clk_in cycles per SCK half-period (>=1).
REQ-004 SHALL have clk_in  input  1  single clock for all logic.
REQ-005 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have spi_cs_pin  output  1  flash chip select, active-low.
REQ-007 SHALL have spi_clk_pin  output  1  SCK, mode 0 (idle low).
REQ-008 SHALL have spi_mosi_pin  output  1  command/address serial out, MSB first.
REQ-009 SHALL have spi_miso_pin  input  1  flash serial data in.
REQ-010 SHALL have itcm_wr_addr  output  32  ITCM word address (word index, not byte).
REQ-011 SHALL have itcm_wr_data  output  32  word to write.
REQ-012 SHALL have itcm_wren  output  1  one-cycle write strobe.
REQ-013 SHALL have core_rst_n  output  1  held low until image copied; feeds core rst_n.
REQ-014 SHALL have boot_done  output  1  high once copy complete, until next reset.

Function
REQ-015 SHALL implement FSM IDLE -> CMD -> ADDR -> DATA -> FINISH -> DONE.
REQ-016 IDLE SHALL last exactly one cycle after rst_n high, then drive spi_cs_pin low and enter CMD.
REQ-017 CMD SHALL shift out 8'h03 (READ), ADDR SHALL shift out FLASH_BASE[23:0], both MSB first.
REQ-018 SCK SHALL toggle every CLK_DIV cycles; one bit = 2*CLK_DIV cycles; MOSI changes only while SCK low; MISO sampled on SCK rising edge.
REQ-019 DATA SHALL receive 4*WORD_COUNT bytes back-to-back, no SCK gaps between bytes or words.
REQ-020 Each byte SHALL assemble MSB-first; bytes SHALL pack little-endian (byte 0 -> bits [7:0]).
REQ-021 On the cycle after the 4th byte's last sample, itcm_wren SHALL pulse 1 cycle with itcm_wr_addr = word index and completed data; shifting of next word SHALL continue unstalled.
REQ-022 Word index SHALL start at 0, increment by 1 per write, never wrap; last write index = WORD_COUNT-1.
REQ-023 After final write strobe, FINISH SHALL hold SCK low and raise spi_cs_pin on the next cycle.
REQ-024 DONE SHALL assert boot_done and core_rst_n on the cycle after CS rises; both stay high, all SPI outputs idle, until reset.
REQ-025 itcm_wr_addr/itcm_wr_data SHALL hold their last values when itcm_wren is low.
REQ-026 WORD_COUNT=1 SHALL produce exactly one write at index 0.
REQ-027 Total SCK rising edges per boot SHALL equal 32 + 32*WORD_COUNT.

Reset
REQ-028 While rst_n low: spi_cs_pin=1, spi_clk_pin=0, spi_mosi_pin=0, itcm_wren=0, itcm_wr_addr=0, itcm_wr_data=0, core_rst_n=0, boot_done=0, state=IDLE.
REQ-029 Reset asserted mid-transfer SHALL abort at the next clk_in edge (CS high, no further writes) and restart from word 0 on release.

Structure
REQ-030 READ opcode 8'h03 and FSM state encodings SHALL live in the shared SoC constants include.
REQ-031 SHALL contain one sub-module spi_byte_shifter (mode 0, CLK_DIV-parameterised, full-duplex byte shift with done pulse).
REQ-032 SHALL sit between power-on reset and core: core_rst_n drives core rst_n; ITCM write port drives itcm_ram address/data/wren during boot.

Verification
REQ-033 CLK_DIV=2, WORD_COUNT=4, flash bytes 00..0F -> writes idx0..3 = 32'h03020100, 07060504, 0B0A0908, 0F0E0D0C; core_rst_n rises after 4th write.
REQ-034 FLASH_BASE=24'h012345 -> MOSI first 32 bits = 32'h03012345; SCK period 4 clk_in cycles; 160 SCK rising edges total.
REQ-035 rst_n pulsed low during word 2 -> CS high next cycle, no write idx2; after release writes restart at idx0 with identical data.
REQ-036 WORD_COUNT=1, CLK_DIV=1, bytes DE AD BE EF -> single write idx0 = 32'hEFBEADDE, boot_done high, CS high, SCK low thereafter.
REQ-037 Any config -> itcm_wren never high on consecutive cycles; exactly WORD_COUNT strobes; core_rst_n low throughout transfer.

Source files
------------

// File: rtl/itcm_boot_loader_pkg.sv
// Shared boot-loader constants: flash opcode, FSM encoding and ITCM write payload.
package itcm_boot_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [BYTE_W-1:0] READ_CMD = 8'h03;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        FINISH = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } itcm_wr_t;

endpackage

// File: rtl/itcm_boot_loader_spi_byte_shifter.sv
// Mode-0 SPI byte shifter: full duplex, MSB first, chains bytes with no SCK gap while 'more' is high.
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       more,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       done_c,
    output logic       byte_end_c,
    output logic [7:0] rx_next_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             busy;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       tx_sr;
    logic [6:0]       rx_sr;
    logic             tick;

    assign tick       = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign done_c     = tick && !sck && (bit_cnt == 3'd7);
    assign byte_end_c = tick && sck && (bit_cnt == 3'd7);
    assign rx_next_c  = {rx_sr, miso};

    // tx_sr holds only the bits still to be sent; the current bit already sits on mosi
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                busy    <= 1'b1;
                div_cnt <= '0;
                bit_cnt <= '0;
                sck     <= 1'b0;
                tx_sr   <= tx_byte[6:0];
                mosi    <= tx_byte[7];
            end
        end else if (!tick) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end else begin
            div_cnt <= '0;
            if (!sck) begin
                sck   <= 1'b1;
                rx_sr <= rx_next_c[6:0];
            end else begin
                sck <= 1'b0;
                if (bit_cnt == 3'd7) begin
                    bit_cnt <= '0;
                    if (more) begin
                        tx_sr <= tx_byte[6:0];
                        mosi  <= tx_byte[7];
                    end else begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    mosi    <= tx_sr[6];
                    tx_sr   <= {tx_sr[5:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/itcm_boot_loader.sv
// Copies a flash image into ITCM over SPI READ, holding the core in reset until the copy completes.
module itcm_boot_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int unsigned WORD_COUNT = 1024,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    output logic        spi_cs_pin,
    output logic        spi_clk_pin,
    output logic        spi_mosi_pin,
    input  logic        spi_miso_pin,
    output logic [31:0] itcm_wr_addr,
    output logic [31:0] itcm_wr_data,
    output logic        itcm_wren,
    output logic        core_rst_n,
    output logic        boot_done
);

    import itcm_boot_loader_pkg::*;

    state_t     state, next_state;
    itcm_wr_t   wr;
    logic [1:0] hdr_idx;
    logic [1:0] byte_sel;
    logic [16:0] word_idx;
    logic        last_seen;
    logic [23:0] word_buf;
    logic [7:0]  tx_byte_c;
    logic        start_c;
    logic        more_c;
    logic        done_c;
    logic        byte_end_c;
    logic [7:0]  rx_next_c;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk_in),
        .rst_n      (rst_n),
        .start      (start_c),
        .more       (more_c),
        .tx_byte    (tx_byte_c),
        .miso       (spi_miso_pin),
        .sck        (spi_clk_pin),
        .mosi       (spi_mosi_pin),
        .done_c     (done_c),
        .byte_end_c (byte_end_c),
        .rx_next_c  (rx_next_c)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // tx_byte_c is the byte loaded at the next byte boundary, so it selects one byte ahead
    always_comb begin
        next_state = state;
        tx_byte_c  = 8'h00;
        start_c    = 1'b0;
        more_c     = 1'b1;
        case (state)
            IDLE: begin
                tx_byte_c  = READ_CMD;
                start_c    = 1'b1;
                next_state = CMD;
            end
            CMD: begin
                tx_byte_c = FLASH_BASE[23:16];
                if (byte_end_c) next_state = ADDR;
            end
            ADDR: begin
                if (hdr_idx == 2'd0)      tx_byte_c = FLASH_BASE[15:8];
                else if (hdr_idx == 2'd1) tx_byte_c = FLASH_BASE[7:0];
                if (byte_end_c && (hdr_idx == 2'd2)) next_state = DATA;
            end
            DATA: begin
                more_c = !last_seen;
                if (byte_end_c && last_seen) next_state = FINISH;
            end
            FINISH: begin
                more_c     = 1'b0;
                next_state = DONE;
            end
            DONE:    more_c = 1'b0;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            spi_cs_pin <= 1'b1;
            itcm_wren  <= 1'b0;
            wr         <= '0;
            core_rst_n <= 1'b0;
            boot_done  <= 1'b0;
            hdr_idx    <= '0;
            byte_sel   <= '0;
            word_idx   <= '0;
            last_seen  <= 1'b0;
            word_buf   <= '0;
        end else begin
            itcm_wren  <= 1'b0;
            spi_cs_pin <= !(next_state inside {CMD, ADDR, DATA, FINISH});
            core_rst_n <= (state == DONE);
            boot_done  <= (state == DONE);
            if ((state == ADDR) && byte_end_c) hdr_idx <= hdr_idx + 2'd1;
            // little-endian packing: earlier bytes shift down toward bit 0
            if ((state == DATA) && done_c) begin
                byte_sel <= byte_sel + 2'd1;
                if (byte_sel == 2'd3) begin
                    itcm_wren <= 1'b1;
                    wr.addr   <= 32'(word_idx);
                    wr.data   <= {rx_next_c, word_buf};
                    word_idx  <= word_idx + 17'd1;
                    if (word_idx == 17'(WORD_COUNT - 1)) last_seen <= 1'b1;
                end else begin
                    word_buf <= {rx_next_c, word_buf[23:8]};
                end
            end
        end
    end

    assign itcm_wr_addr = wr.addr;
    assign itcm_wr_data = wr.data;

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Two boot-loader configurations against a behavioural SPI flash and ITCM write scoreboard.
module tb_itcm_boot_loader;

    localparam logic [23:0] BASE_A = 24'h012345;
    localparam logic [23:0] BASE_B = 24'h0ABCDE;
    localparam int WC_A  = 4;
    localparam int WC_B  = 1;
    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n, cs, sck, mosi, miso, wren, core, done;
    logic [31:0] addr [2];
    logic [31:0] data [2];

    itcm_boot_loader #(.FLASH_BASE(BASE_A), .WORD_COUNT(WC_A), .CLK_DIV(DIV_A)) u_dut_a (
        .clk_in(clk), .rst_n(rst_n[0]), .spi_cs_pin(cs[0]), .spi_clk_pin(sck[0]),
        .spi_mosi_pin(mosi[0]), .spi_miso_pin(miso[0]), .itcm_wr_addr(addr[0]),
        .itcm_wr_data(data[0]), .itcm_wren(wren[0]), .core_rst_n(core[0]), .boot_done(done[0]));

    itcm_boot_loader #(.FLASH_BASE(BASE_B), .WORD_COUNT(WC_B), .CLK_DIV(DIV_B)) u_dut_b (
        .clk_in(clk), .rst_n(rst_n[1]), .spi_cs_pin(cs[1]), .spi_clk_pin(sck[1]),
        .spi_mosi_pin(mosi[1]), .spi_miso_pin(miso[1]), .itcm_wr_addr(addr[1]),
        .itcm_wr_data(data[1]), .itcm_wren(wren[1]), .core_rst_n(core[1]), .boot_done(done[1]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  img [2][16];
    logic [31:0] hdr [2];
    int          rises [2];
    int          last_rise [2];
    int          gap_min [2];
    int          gap_max [2];
    int          exp_idx [2];
    int          cs_hi_cnt [2];
    logic [1:0]  prev_sck = '0;
    logic [1:0]  prev_wren = '0;
    int          k;
    int          gap;
    logic [7:0]  fb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] base_of(input int d);
        return (d == 0) ? BASE_A : BASE_B;
    endfunction
    function automatic int wc_of(input int d);
        return (d == 0) ? WC_A : WC_B;
    endfunction
    function automatic int div_of(input int d);
        return (d == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic logic [7:0] flash_byte(input int d, input logic [23:0] a);
        logic [23:0] off;
        off = a - base_of(d);
        if (off < 24'(4 * wc_of(d))) return img[d][off[3:0]];
        return 8'hFF;
    endfunction

    function automatic logic [31:0] exp_word(input int d, input int i);
        return {img[d][4*i+3], img[d][4*i+2], img[d][4*i+1], img[d][4*i]};
    endfunction

    // flash model (drives MISO after SCK falls) and ITCM write scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            cs_hi_cnt[d] = cs[d] ? cs_hi_cnt[d] + 1 : 0;
            if (!cs[d]) begin
                if (sck[d] && !prev_sck[d]) begin
                    if (rises[d] < 32) hdr[d] = {hdr[d][30:0], mosi[d]};
                    if (rises[d] > 0) begin
                        gap = cyc - last_rise[d];
                        if (gap < gap_min[d]) gap_min[d] = gap;
                        if (gap > gap_max[d]) gap_max[d] = gap;
                    end
                    last_rise[d] = cyc;
                    rises[d]++;
                end
                if (!sck[d] && prev_sck[d] && rises[d] >= 32) begin
                    k  = rises[d] - 32;
                    fb = flash_byte(d, hdr[d][23:0] + 24'(k / 8));
                    miso[d] = fb[3'(7 - (k % 8))];
                end
            end
            if (wren[d]) begin
                check("wren_back_to_back", 32'(prev_wren[d]), 32'd0);
                check("core_rst_n_during_copy", 32'(core[d]), 32'd0);
                check("wr_in_range", 32'(exp_idx[d] < wc_of(d)), 32'd1);
                if (exp_idx[d] < wc_of(d)) begin
                    check("wr_addr", addr[d], 32'(exp_idx[d]));
                    check("wr_data", data[d], exp_word(d, exp_idx[d]));
                end
                exp_idx[d]++;
            end
            prev_sck[d]  = sck[d];
            prev_wren[d] = wren[d];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_boot(input int d);
        rst_n[d] = 1'b0;
        repeat (3) tick();
        exp_idx[d] = 0;
        rises[d]   = 0;
        hdr[d]     = '0;
        gap_min[d] = 100000;
        gap_max[d] = 0;
        rst_n[d]   = 1'b1;
    endtask

    // mode: 0 = ramp 00..0F, 1 = random, 2 = DE AD BE EF, 3 = keep current image
    task automatic do_boot(input int d, input int mode);
        int n;
        for (int i = 0; i < 16; i++) begin
            if (mode == 0) img[d][i] = 8'(i);
            else if (mode == 1) img[d][i] = 8'($urandom);
        end
        if (mode == 2) begin
            img[d][0] = 8'hDE; img[d][1] = 8'hAD; img[d][2] = 8'hBE; img[d][3] = 8'hEF;
        end
        start_boot(d);
        n = 0;
        while (!done[d] && n < 5000) begin
            tick();
            n++;
        end
        check("boot_timeout", 32'(done[d]), 32'd1);
        check("cs_high_one_cycle_before_done", 32'(cs_hi_cnt[d]), 32'd2);
        check("core_rst_n_at_done", 32'(core[d]), 32'd1);
        check("wr_count", 32'(exp_idx[d]), 32'(wc_of(d)));
        check("mosi_header", hdr[d], {8'h03, base_of(d)});
        check("sck_rises", 32'(rises[d]), 32'(32 + 32 * wc_of(d)));
        check("sck_period_min", 32'(gap_min[d]), 32'(2 * div_of(d)));
        check("sck_period_max", 32'(gap_max[d]), 32'(2 * div_of(d)));
        check("last_addr_held", addr[d], 32'(wc_of(d) - 1));
        check("last_data_held", data[d], exp_word(d, wc_of(d) - 1));
        if (mode == 0) check("ramp_word3", data[d], 32'h0F0E0D0C);
        if (mode == 2) check("deadbeef_word", data[d], 32'hEFBEADDE);
        repeat (10) tick();
        check("cs_idle", 32'(cs[d]), 32'd1);
        check("sck_idle", 32'(sck[d]), 32'd0);
        check("mosi_idle", 32'(mosi[d]), 32'd0);
        check("boot_done_held", 32'(done[d]), 32'd1);
        check("core_rst_n_held", 32'(core[d]), 32'd1);
        check("no_extra_writes", 32'(exp_idx[d]), 32'(wc_of(d)));
    endtask

    initial begin
        int n;
        rst_n = 2'b00;
        miso  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            exp_idx[d] = 0; rises[d] = 0; hdr[d] = '0; cs_hi_cnt[d] = 0;
            last_rise[d] = 0; gap_min[d] = 100000; gap_max[d] = 0;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_cs", 32'(cs[d]), 32'd1);
            check("rst_sck", 32'(sck[d]), 32'd0);
            check("rst_mosi", 32'(mosi[d]), 32'd0);
            check("rst_wren", 32'(wren[d]), 32'd0);
            check("rst_addr", addr[d], 32'd0);
            check("rst_data", data[d], 32'd0);
            check("rst_core_rst_n", 32'(core[d]), 32'd0);
            check("rst_boot_done", 32'(done[d]), 32'd0);
        end

        do_boot(0, 0);
        do_boot(1, 2);
        for (int r = 0; r < 2; r++) begin
            do_boot(0, 1);
            do_boot(1, 1);
        end

        // abort during word 2, then expect a full restart from word 0 with the same image
        for (int i = 0; i < 16; i++) img[0][i] = 8'($urandom);
        start_boot(0);
        n = 0;
        while (exp_idx[0] < 2 && n < 5000) begin
            tick();
            n++;
        end
        check("abort_reach_word2", 32'(exp_idx[0]), 32'd2);
        repeat (20) tick();
        rst_n[0] = 1'b0;
        tick();
        check("abort_cs_high", 32'(cs[0]), 32'd1);
        check("abort_sck_low", 32'(sck[0]), 32'd0);
        check("abort_wren_low", 32'(wren[0]), 32'd0);
        repeat (4) tick();
        check("abort_no_idx2_write", 32'(exp_idx[0]), 32'd2);
        do_boot(0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
